uart_rx_ctrl: RTL

- Parametrised UART receive controller: oversamples a serial line on `CLOCK_50`, validates the start bit and samples each data bit mid-period.
- Assembles LSB-first data in an internal shift register and checks optional parity and the stop bit, then presents a word with a one-cycle valid strobe and error flags.
- Replaces the fixed-rate, fixed-length receive FSM plus external shift-register pairing; sits between the board RX pin and the RAM write/address-counter logic.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_ctrl_if.sv | 31 +++
 rtl/uart_baud_timer.sv | 42 ++++
 rtl/uart_rx_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   PAR_*       parity-mode constants for the PARITY parameter
//   rx_state_e  receive FSM state encoding
//   cpb()       clocks per bit from clock frequency and line rate
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_DONE  = 3'd5,
    ST_BRK   = 3'd6
  } rx_state_e;

  function automatic int cpb(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: received-word bundle from the UART receiver to the
// RAM write / address-counter logic.
//   data          last received word, held until the next data_valid
//   data_valid    one-cycle strobe per completed frame
//   parity_err    parity result of the last frame (held)
//   frame_err     stop bit sampled low on the last frame (held)
//   busy          receiver is not idle
//   RShift        one-cycle pulse per data-bit sample (legacy shifters)
//   enableCounter one-cycle pulse with data_valid when the frame is clean
// master: the receiver; slave: the consumer.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;
  logic                 RShift;
  logic                 enableCounter;

  modport master (
    output data, data_valid, parity_err, frame_err, busy, RShift, enableCounter
  );

  modport slave (
    input  data, data_valid, parity_err, frame_err, busy, RShift, enableCounter
  );

endinterface

// File: rtl/uart_baud_timer.sv
// uart_baud_timer: bit-period down-counter.
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       restart the count (from HALF when load_half, else CPB)
//   load_half   selects the half-bit period on clear
//   tick        high in the cycle the count reaches zero; the counter then
//               reloads CPB so successive ticks are one bit period apart
module uart_baud_timer #(
  parameter int CPB  = 434,
  parameter int HALF = CPB / 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load_half,
  output logic tick
);

  localparam int W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [W-1:0] RELOAD_FULL = W'(CPB - 1);
  localparam logic [W-1:0] RELOAD_HALF = W'(HALF - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = load_half ? RELOAD_HALF : RELOAD_FULL;
    end else if (cnt_q == '0) begin
      cnt_d = RELOAD_FULL;
    end else begin
      cnt_d = cnt_q - W'(1);
    end
  end

  assign tick = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= RELOAD_FULL;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: parametrised UART receive controller.
//   CLOCK_50  clock (rising edge)
//   Reset_n   asynchronous active-low reset
//   rx        asynchronous serial input, idle high
//   bus       uart_rx_ctrl_if.master: received word, strobes and flags
// The line is synchronised, a falling edge starts a frame, the start bit is
// re-checked at half a bit, then data (LSB first), optional parity and the
// stop bit are sampled one bit period apart.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE
) (
  input  logic           CLOCK_50,
  input  logic           Reset_n,
  input  logic           rx,
  uart_rx_ctrl_if.master bus
);

  localparam int CPB  = cpb(CLK_HZ, BAUD);
  localparam int HALF = CPB / 2;
  localparam int IW   = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  if (CPB < 4) begin : g_bad_cpb
    $error("uart_rx_ctrl: CLK_HZ/BAUD must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_rx_ctrl: DATA_BITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
    $error("uart_rx_ctrl: PARITY must be 0, 1 or 2");
  end

  // Synchroniser and previous-sample flops reset low: a line held low
  // through reset never looks like a falling edge until it has gone high.
  logic sync1_q, sync2_q, prev_q;

  rx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
  logic                 rshift_q, rshift_d;
  logic                 en_cnt_q, en_cnt_d;

  logic timer_clear;
  logic tick;
  logic fall;
  logic perr_eff;

  uart_baud_timer #(
    .CPB  (CPB),
    .HALF (HALF)
  ) u_timer (
    .clk       (CLOCK_50),
    .rst_n     (Reset_n),
    .clear     (timer_clear),
    .load_half (1'b1),
    .tick      (tick)
  );

  assign fall     = prev_q & ~sync2_q;
  assign perr_eff = (PARITY == PAR_NONE) ? 1'b0 : perr_q;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    perr_d       = perr_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rshift_d     = 1'b0;
    en_cnt_d     = 1'b0;
    timer_clear  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          timer_clear = 1'b1;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (sync2_q) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = '0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d  = {sync2_q, shift_q[DATA_BITS-1:1]};
          rshift_d = 1'b1;
          idx_d    = idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PAR;
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          perr_d  = ((^shift_q) ^ sync2_q) != (PARITY == PAR_ODD);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Result registers load on the transition into DONE so that
        // data_valid and the flags are visible for the single DONE cycle.
        if (tick) begin
          data_d       = shift_q;
          parity_err_d = perr_eff;
          frame_err_d  = ~sync2_q;
          data_valid_d = 1'b1;
          en_cnt_d     = sync2_q & ~perr_eff;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = sync2_q ? ST_IDLE : ST_BRK;
      end
      ST_BRK: begin
        if (sync2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      perr_q       <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      rshift_q     <= 1'b0;
      en_cnt_q     <= 1'b0;
    end else begin
      sync1_q      <= rx;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      perr_q       <= perr_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      rshift_q     <= rshift_d;
      en_cnt_q     <= en_cnt_d;
    end
  end

  assign bus.data          = data_q;
  assign bus.data_valid    = data_valid_q;
  assign bus.parity_err    = parity_err_q;
  assign bus.frame_err     = frame_err_q;
  assign bus.busy          = busy_q;
  assign bus.RShift        = rshift_q;
  assign bus.enableCounter = en_cnt_q;

endmodule
